// File: rtl/policy_server_axil_slave.sv
// policy_server_axil_slave: AXI4-Lite register file holding the Policy Server policy registers
module policy_server_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [32*NUM_REGS-1:0]            policy_regs,
    output logic [NUM_REGS-1:0]               policy_wr_pulse
);
    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t                      w_state;
    r_state_t                      r_state;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [31:0]                   w_data;
    logic [3:0]                    w_strb;
    logic                          aw_hs;
    logic                          w_hs;
    logic                          commit;
    logic [C_S_AXI_ADDR_WIDTH-1:0] c_addr;
    logic [31:0]                   c_data;
    logic [3:0]                    c_strb;
    logic [IW-1:0]                 w_idx;
    logic [IW-1:0]                 r_idx;
    logic                          w_in;
    logic                          r_in;
    logic [31:0]                   r_word;
    logic                          unused;

    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, c_addr[1:0], S_AXI_ARADDR[1:0]};

    // Merge live channel values with held ones so the commit uses whichever arrived last
    always_comb begin
        aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
        w_hs   = S_AXI_WVALID & S_AXI_WREADY;
        commit = (w_state == W_IDLE) & (aw_hs | ~S_AXI_AWREADY) & (w_hs | ~S_AXI_WREADY);
        c_addr = aw_hs ? S_AXI_AWADDR : aw_addr;
        c_data = w_hs ? S_AXI_WDATA : w_data;
        c_strb = w_hs ? S_AXI_WSTRB : w_strb;
        w_idx  = c_addr[C_S_AXI_ADDR_WIDTH-1:2];
        r_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
        w_in   = {1'b0, w_idx} < (IW+1)'(NUM_REGS);
        r_in   = {1'b0, r_idx} < (IW+1)'(NUM_REGS);
        r_word = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (r_idx == IW'(k)) r_word = policy_regs[32*k +: 32];
    end

    // Write FSM: capture AW and W independently, commit once both are present, then hold B
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state         <= W_IDLE;
            S_AXI_AWREADY   <= 1'b1;
            S_AXI_WREADY    <= 1'b1;
            S_AXI_BVALID    <= 1'b0;
            S_AXI_BRESP     <= 2'b00;
            aw_addr         <= '0;
            w_data          <= '0;
            w_strb          <= '0;
            policy_regs     <= '0;
            policy_wr_pulse <= '0;
        end else begin
            policy_wr_pulse <= '0;
            if (w_state == W_IDLE) begin
                if (aw_hs) begin
                    aw_addr       <= S_AXI_AWADDR;
                    S_AXI_AWREADY <= 1'b0;
                end
                if (w_hs) begin
                    w_data       <= S_AXI_WDATA;
                    w_strb       <= S_AXI_WSTRB;
                    S_AXI_WREADY <= 1'b0;
                end
                if (commit) begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        for (int b = 0; b < 4; b++)
                            if (w_in && w_idx == IW'(k) && c_strb[b])
                                policy_regs[32*k+8*b +: 8] <= c_data[8*b +: 8];
                        policy_wr_pulse[k] <= w_in && w_idx == IW'(k);
                    end
                    S_AXI_BRESP  <= w_in ? 2'b00 : 2'b10;
                    S_AXI_BVALID <= 1'b1;
                    w_state      <= W_RESP;
                end
            end else if (S_AXI_BREADY) begin
                S_AXI_BVALID  <= 1'b0;
                S_AXI_AWREADY <= 1'b1;
                S_AXI_WREADY  <= 1'b1;
                w_state       <= W_IDLE;
            end
        end
    end

    // Read FSM: sample the register on the AR handshake (pre-write value on a collision), hold R
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b1;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RRESP   <= 2'b00;
            S_AXI_RDATA   <= '0;
        end else if (r_state == R_IDLE) begin
            if (S_AXI_ARVALID) begin
                S_AXI_RDATA   <= r_word;
                S_AXI_RRESP   <= r_in ? 2'b00 : 2'b10;
                S_AXI_RVALID  <= 1'b1;
                S_AXI_ARREADY <= 1'b0;
                r_state       <= R_RESP;
            end
        end else if (S_AXI_RREADY) begin
            S_AXI_RVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
            r_state       <= R_IDLE;
        end
    end
endmodule

// File: tb/tb_policy_server_axil_slave.sv
// tb_policy_server_axil_slave: directed checks of the policy register AXI4-Lite slave
module tb_policy_server_axil_slave;
    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [5:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [5:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [127:0] policy_regs;
    logic [3:0]  policy_wr_pulse;

    logic [31:0] mdl [4];
    int n_chk = 0;
    int n_pass = 0;

    policy_server_axil_slave dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .policy_regs(policy_regs), .policy_wr_pulse(policy_wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk_regs(input string tag);
        for (int k = 0; k < 4; k++) chk(tag, policy_regs[32*k +: 32], mdl[k]);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s, input int hold);
        int idx;
        logic [1:0] er;
        logic [3:0] ep;
        idx = int'(a[5:2]);
        er = idx < 4 ? 2'b00 : 2'b10;
        ep = idx < 4 ? 4'(1 << idx) : 4'b0000;
        if (idx < 4)
            for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
        chk("awready_idle", S_AXI_AWREADY, 1);
        chk("wready_idle", S_AXI_WREADY, 1);
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = (hold == 0);
        tick();
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        chk("bvalid_t1", S_AXI_BVALID, 1);
        chk("bresp", S_AXI_BRESP, er);
        chk("wr_pulse", policy_wr_pulse, ep);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("bvalid_hold", S_AXI_BVALID, 1);
            chk("bresp_hold", S_AXI_BRESP, er);
            chk("awready_hold", S_AXI_AWREADY, 0);
            chk("wready_hold", S_AXI_WREADY, 0);
        end
        S_AXI_BREADY = 1;
        tick();
        chk("bvalid_done", S_AXI_BVALID, 0);
        chk("awready_done", S_AXI_AWREADY, 1);
        chk("wready_done", S_AXI_WREADY, 1);
        chk("wr_pulse_clear", policy_wr_pulse, 0);
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] ed, input logic [1:0] er, input int hold);
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1; S_AXI_RREADY = (hold == 0);
        tick();
        S_AXI_ARVALID = 0;
        chk("rvalid_t1", S_AXI_RVALID, 1);
        chk("rdata", S_AXI_RDATA, ed);
        chk("rresp", S_AXI_RRESP, er);
        chk("arready_busy", S_AXI_ARREADY, 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("rvalid_hold", S_AXI_RVALID, 1);
            chk("rdata_hold", S_AXI_RDATA, ed);
            chk("rresp_hold", S_AXI_RRESP, er);
            chk("arready_hold", S_AXI_ARREADY, 0);
        end
        S_AXI_RREADY = 1;
        tick();
        chk("rvalid_done", S_AXI_RVALID, 0);
        chk("arready_done", S_AXI_ARREADY, 1);
    endtask

    initial begin
        ARESETN = 0;
        S_AXI_AWADDR = 0; S_AXI_AWPROT = 0; S_AXI_AWVALID = 0;
        S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
        S_AXI_ARADDR = 0; S_AXI_ARPROT = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
        for (int k = 0; k < 4; k++) mdl[k] = 0;
        repeat (3) tick();
        chk("rst_awready", S_AXI_AWREADY, 1);
        chk("rst_wready", S_AXI_WREADY, 1);
        chk("rst_arready", S_AXI_ARREADY, 1);
        chk("rst_bvalid", S_AXI_BVALID, 0);
        chk("rst_rvalid", S_AXI_RVALID, 0);
        chk("rst_bresp", S_AXI_BRESP, 0);
        chk("rst_rresp", S_AXI_RRESP, 0);
        chk("rst_rdata", S_AXI_RDATA, 0);
        chk("rst_pulse", policy_wr_pulse, 0);
        chk_regs("rst_reg");
        ARESETN = 1;
        tick();

        // sequential writes then read-back
        for (int k = 0; k < 4; k++) wr(6'(4*k), 32'(k+1), 4'hF, 0);
        for (int k = 0; k < 4; k++) rd(6'(4*k), 32'(k+1), 2'b00, 0);
        chk_regs("seq_reg");

        // W leads AW by three cycles
        S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1; S_AXI_BREADY = 1;
        tick();
        S_AXI_WVALID = 0;
        chk("wlead_wready", S_AXI_WREADY, 0);
        chk("wlead_awready", S_AXI_AWREADY, 1);
        chk("wlead_bvalid", S_AXI_BVALID, 0);
        tick();
        tick();
        chk("wlead_bvalid2", S_AXI_BVALID, 0);
        chk("wlead_reg2", policy_regs[95:64], 32'h3);
        S_AXI_AWADDR = 6'h08; S_AXI_AWVALID = 1;
        tick();
        S_AXI_AWVALID = 0;
        mdl[2] = 32'hDEADBEEF;
        chk("wlead_bvalid3", S_AXI_BVALID, 1);
        chk("wlead_bresp", S_AXI_BRESP, 0);
        chk("wlead_pulse", policy_wr_pulse, 4'b0100);
        tick();
        chk("wlead_bdone", S_AXI_BVALID, 0);
        chk("wlead_wready2", S_AXI_WREADY, 1);
        rd(6'h08, 32'hDEADBEEF, 2'b00, 0);

        // byte strobes
        wr(6'h04, 32'h11223344, 4'hF, 0);
        wr(6'h04, 32'hAABBCCDD, 4'b0101, 0);
        rd(6'h04, 32'h11BB33DD, 2'b00, 0);
        wr(6'h0C, 32'h0BADF00D, 4'b0000, 0);
        chk_regs("strb_reg");

        // out of range
        wr(6'h10, 32'h55, 4'hF, 0);
        chk_regs("oor_reg");
        rd(6'h3C, 32'h0, 2'b10, 0);

        // backpressure
        wr(6'h0C, 32'h12345678, 4'hF, 5);
        wr(6'h20, 32'h99, 4'hF, 5);
        rd(6'h0C, 32'h12345678, 2'b00, 5);
        rd(6'h24, 32'h0, 2'b10, 5);

        // write/read collision on reg0
        wr(6'h00, 32'h1, 4'hF, 0);
        S_AXI_AWADDR = 6'h00; S_AXI_WDATA = 32'h9; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 1;
        S_AXI_ARADDR = 6'h00; S_AXI_ARVALID = 1; S_AXI_RREADY = 1;
        tick();
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
        mdl[0] = 32'h9;
        chk("coll_rvalid", S_AXI_RVALID, 1);
        chk("coll_rdata", S_AXI_RDATA, 32'h1);
        chk("coll_bvalid", S_AXI_BVALID, 1);
        tick();
        rd(6'h00, 32'h9, 2'b00, 0);
        chk_regs("coll_reg");

        // reset while BVALID is high
        S_AXI_AWADDR = 6'h04; S_AXI_WDATA = 32'h77; S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 0;
        tick();
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        chk("prerst_bvalid", S_AXI_BVALID, 1);
        #2 ARESETN = 0;
        #1;
        for (int k = 0; k < 4; k++) mdl[k] = 0;
        chk("arst_bvalid", S_AXI_BVALID, 0);
        chk("arst_awready", S_AXI_AWREADY, 1);
        chk_regs("arst_reg");
        tick();
        ARESETN = 1;
        S_AXI_BREADY = 1;
        tick();
        chk("postrst_bvalid", S_AXI_BVALID, 0);

        // W captured then reset: a later lone AW must not commit
        S_AXI_WDATA = 32'hCAFE; S_AXI_WVALID = 1;
        tick();
        S_AXI_WVALID = 0;
        chk("abort_wready", S_AXI_WREADY, 0);
        ARESETN = 0;
        #1;
        chk("abort_wready_rst", S_AXI_WREADY, 1);
        tick();
        ARESETN = 1;
        S_AXI_AWADDR = 6'h08; S_AXI_AWVALID = 1;
        tick();
        S_AXI_AWVALID = 0;
        chk("abort_bvalid", S_AXI_BVALID, 0);
        chk("abort_pulse", policy_wr_pulse, 0);
        tick();
        chk_regs("abort_reg");
        S_AXI_WDATA = 32'h5A5A5A5A; S_AXI_WVALID = 1;
        tick();
        S_AXI_WVALID = 0;
        mdl[2] = 32'h5A5A5A5A;
        chk("abort_commit", S_AXI_BVALID, 1);
        tick();
        rd(6'h08, 32'h5A5A5A5A, 2'b00, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
